// File: rtl/bt_uart_pkg.sv
// Shared types and constants for the Bluetooth UART receiver.
// Provides the FSM state enum and the baud divisor helper.
package bt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 8;
  localparam int DATA_BITS  = 8;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick divider: counts 0..DIV-1, tick on DIV-1.
// Ports: clk, rst_n (async low), clr (sync clear), tick (1-cycle).
module baud_tick_gen #(
  parameter int DIV = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bt_uart_rx.sv
// HC-05 UART receiver: 2-flop sync, 16x oversample, 8N1 framing.
// Ports: WF_CLK, WF_BUTTON (async low rst), rx -> rx_data, rx_valid,
// frame_err, busy. Optional CMD_TIMEOUT_EN forces rx_data to 0 on silence.
module bt_uart_rx #(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int TIMEOUT_MS = 250
) (
  input  logic       WF_CLK,
  input  logic       WF_BUTTON,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  import bt_uart_pkg::*;

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = $clog2(bt_uart_pkg::OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  if (OVERSAMPLE != bt_uart_pkg::OVERSAMPLE) begin : g_os_chk
    $error("bt_uart_rx: OVERSAMPLE must be 16");
  end

  logic          rx_m;
  logic          rx_s;
  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] last_cnt;
  logic [BW-1:0] bit_cnt;
  logic [7:0]    shreg;
  logic          tick;
  logic          clr;
  logic          bit_done;
  logic          stop_done;
  logic          load;

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (WF_CLK),
    .rst_n (WF_BUTTON),
    .clr   (clr),
    .tick  (tick)
  );

  // START waits half a bit to land mid-bit; later states wait a full bit.
  assign last_cnt  = (state_q == START) ? TW'(MID_TICK - 1)
                                        : TW'(bt_uart_pkg::OVERSAMPLE - 1);
  assign bit_done  = tick && (tick_cnt == last_cnt);
  assign stop_done = (state_q == STOP) && bit_done;
  assign load      = stop_done && rx_s;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          clr     = 1'b1;
        end
      end
      START: begin
        if (bit_done) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done && bit_cnt == BW'(DATA_BITS - 1)) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (clr) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (bit_done) begin
        tick_cnt <= '0;
      end else if (tick && busy) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (state_q == DATA && bit_done) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {rx_s, shreg[7:1]};
      end
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TO_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int OW     = $clog2(TO_CYC + 1);

  logic [OW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = (to_cnt == OW'(TO_CYC - 1));

  // Restarts on every good byte; saturates so REST is forced only once.
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      to_cnt <= '0;
    end else if (load) begin
      to_cnt <= '0;
    end else if (to_cnt != OW'(TO_CYC)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  if (TIMEOUT_MS < 1) begin : g_to_chk
    $error("bt_uart_rx: TIMEOUT_MS must be >= 1");
  end
`endif

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load;
      frame_err <= stop_done && !rx_s;
      if (load) begin
        rx_data <= shreg;
      end
`ifdef CMD_TIMEOUT_EN
      else if (to_hit) begin
        rx_data <= 8'h00;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bt_uart_rx.sv
// Directed bench for bt_uart_rx at 100 kbaud on a 16 MHz clock.
// Checks reset, framing, glitch rejection, tolerance and timeout.
module tb_bt_uart_rx;

  localparam int BIT  = 160;
  localparam int FAST = 157;
  localparam int SLOW = 163;

  logic       WF_CLK = 1'b0;
  logic       WF_BUTTON = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int asserts = 0;
  int fails = 0;
  int vcnt = 0;
  int ecnt = 0;
  int seq_err = 0;
  int vcyc = 0;
  int edge_cyc = 0;
  int cyc = 0;
  logic pv = 1'b0;
  logic pe = 1'b0;
  logic [7:0] got_q[$];

  bt_uart_rx #(
    .CLK_HZ     (16000000),
    .BAUD       (100000),
    .OVERSAMPLE (16),
    .TIMEOUT_MS (1)
  ) dut (
    .WF_CLK    (WF_CLK),
    .WF_BUTTON (WF_BUTTON),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 WF_CLK = ~WF_CLK;

  always @(posedge WF_CLK) cyc <= cyc + 1;

  always @(negedge WF_CLK) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      vcnt++;
      vcyc = cyc;
    end
    if (frame_err) ecnt++;
    if ((rx_valid && frame_err) || (rx_valid && pe) || (frame_err && pv))
      seq_err++;
    pv = rx_valid;
    pe = frame_err;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge WF_CLK);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int bc);
    rx = 1'b0;
    edge_cyc = cyc;
    cyc_wait(bc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc_wait(bc);
    end
    rx = stop;
    cyc_wait(bc);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) begin
      rx = ~rx;
      @(negedge WF_CLK);
      asserts++;
      if ({rx_data, rx_valid, frame_err, busy} !== 11'h0) begin
        fails++;
        $display("FAIL reset_hold: got %h want 000", {rx_data, rx_valid, frame_err, busy});
      end
    end
    rx = 1'b1;
    @(negedge WF_CLK);
    WF_BUTTON = 1'b1;
    cyc_wait(40);
    asserts++;
    if ({rx_data, rx_valid, frame_err, busy} !== 11'h0) begin
      fails++;
      $display("FAIL reset_release: got %h want 000", {rx_data, rx_valid, frame_err, busy});
    end
    asserts++;
    if (vcnt !== 0 || ecnt !== 0) begin
      fails++;
      $display("FAIL reset_strobes: got v=%0d e=%0d want 0 0", vcnt, ecnt);
    end
  endtask

  task automatic test_single;
    int v0;
    int lat;
    v0 = vcnt;
    send(8'hC5, 1'b1, BIT);
    cyc_wait(20);
    asserts++;
    if (vcnt - v0 !== 1) begin
      fails++;
      $display("FAIL single_count: got %0d want 1", vcnt - v0);
    end
    asserts++;
    if (rx_data !== 8'hC5) begin
      fails++;
      $display("FAIL single_data: got %h want c5", rx_data);
    end
    lat = vcyc - edge_cyc;
    asserts++;
    if (lat < 1522 || lat > 1524) begin
      fails++;
      $display("FAIL single_latency: got %0d want 1522..1524", lat);
    end
    asserts++;
    if (busy !== 1'b0 || ecnt !== 0) begin
      fails++;
      $display("FAIL single_idle: got busy=%b e=%0d want 0 0", busy, ecnt);
    end
  endtask

  task automatic test_glitch;
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    rx = 1'b0;
    cyc_wait(50);
    rx = 1'b1;
    cyc_wait(200);
    asserts++;
    if (busy !== 1'b0 || vcnt !== v0 || ecnt !== e0) begin
      fails++;
      $display("FAIL glitch_reject: got busy=%b dv=%0d de=%0d want 0 0 0",
               busy, vcnt - v0, ecnt - e0);
    end
    send(8'h81, 1'b1, BIT);
    cyc_wait(20);
    asserts++;
    if (rx_data !== 8'h81 || vcnt !== v0 + 1) begin
      fails++;
      $display("FAIL glitch_next: got %h dv=%0d want 81 1", rx_data, vcnt - v0);
    end
  endtask

  task automatic test_framing;
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    send(8'h3F, 1'b0, BIT);
    cyc_wait(300);
    asserts++;
    if (ecnt !== e0 + 1 || vcnt !== v0) begin
      fails++;
      $display("FAIL frame_strobe: got de=%0d dv=%0d want 1 0", ecnt - e0, vcnt - v0);
    end
    asserts++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL frame_busy_low: got %b want 1", busy);
    end
`ifndef CMD_TIMEOUT_EN
    asserts++;
    if (rx_data !== 8'h81) begin
      fails++;
      $display("FAIL frame_hold: got %h want 81", rx_data);
    end
`endif
    rx = 1'b1;
    cyc_wait(10);
    asserts++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_busy_high: got %b want 0", busy);
    end
    send(8'h40, 1'b1, BIT);
    cyc_wait(20);
    asserts++;
    if (rx_data !== 8'h40 || vcnt !== v0 + 1) begin
      fails++;
      $display("FAIL frame_next: got %h dv=%0d want 40 1", rx_data, vcnt - v0);
    end
  endtask

  task automatic test_back_to_back(input int bc);
    int v0;
    int e0;
    int q0;
    logic [7:0] exp [3];
    exp[0] = 8'h80;
    exp[1] = 8'hC0;
    exp[2] = 8'hFF;
    v0 = vcnt;
    e0 = ecnt;
    q0 = got_q.size();
    for (int i = 0; i < 3; i++) send(exp[i], 1'b1, bc);
    cyc_wait(20);
    asserts++;
    if (vcnt !== v0 + 3 || ecnt !== e0) begin
      fails++;
      $display("FAIL b2b_count bc=%0d: got dv=%0d de=%0d want 3 0",
               bc, vcnt - v0, ecnt - e0);
    end
    for (int i = 0; i < 3; i++) begin
      asserts++;
      if (q0 + i >= got_q.size()) begin
        fails++;
        $display("FAIL b2b_byte%0d bc=%0d: got none want %h", i, bc, exp[i]);
      end else if (got_q[q0+i] !== exp[i]) begin
        fails++;
        $display("FAIL b2b_byte%0d bc=%0d: got %h want %h", i, bc, got_q[q0+i], exp[i]);
      end
    end
    asserts++;
    if (seq_err !== 0) begin
      fails++;
      $display("FAIL b2b_strobe_excl: got %0d want 0", seq_err);
    end
  endtask

  task automatic test_mid_reset;
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    rx = 1'b0;
    cyc_wait(400);
    asserts++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_busy: got %b want 1", busy);
    end
    WF_BUTTON = 1'b0;
    @(negedge WF_CLK);
    asserts++;
    if (busy !== 1'b0 || rx_data !== 8'h00) begin
      fails++;
      $display("FAIL midrst_abort: got busy=%b data=%h want 0 00", busy, rx_data);
    end
    rx = 1'b1;
    cyc_wait(2);
    WF_BUTTON = 1'b1;
    cyc_wait(1700);
    asserts++;
    if (vcnt !== v0 || ecnt !== e0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_quiet: got dv=%0d de=%0d busy=%b want 0 0 0",
               vcnt - v0, ecnt - e0, busy);
    end
  endtask

  task automatic test_timeout;
    int target;
    send(8'hA3, 1'b1, BIT);
    cyc_wait(5);
    asserts++;
    if (rx_data !== 8'hA3) begin
      fails++;
      $display("FAIL to_load: got %h want a3", rx_data);
    end
`ifdef CMD_TIMEOUT_EN
    target = vcyc + 15999;
    while (cyc < target) @(negedge WF_CLK);
    asserts++;
    if (rx_data !== 8'hA3) begin
      fails++;
      $display("FAIL to_before: got %h want a3", rx_data);
    end
    @(negedge WF_CLK);
    asserts++;
    if (rx_data !== 8'h00) begin
      fails++;
      $display("FAIL to_expire: got %h want 00", rx_data);
    end
`else
    target = vcyc + 20000;
    while (cyc < target) @(negedge WF_CLK);
    asserts++;
    if (rx_data !== 8'hA3) begin
      fails++;
      $display("FAIL to_hold: got %h want a3", rx_data);
    end
`endif
  endtask

  initial begin
    @(negedge WF_CLK);
    test_reset;
    test_single;
    test_glitch;
    test_framing;
    test_back_to_back(FAST);
    test_back_to_back(SLOW);
    test_mid_reset;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
